// File: rtl/snapshot_tx_serializer.sv
// Streams a captured snapshot out through uart_tx: one sync header byte, then the
// snapshot bytes LSB first, one byte per tx_start / tx_done_tick handshake.
module snapshot_tx_serializer #(
  parameter int          DATA_W = 1272,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] snapshot_i,
  input  logic              tx_done_tick_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_bus_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NB    = (DATA_W + 7) / 8;
  localparam int CAP_W = 8 * NB;
  localparam int CNT_W = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CAP_W-1:0]   cap_q;
  logic               tx_start_q;
  logic [7:0]         tx_bus_q;
  logic               busy_q;
  logic               done_q;
  logic [CAP_W-1:0]   cap_d;

  // The capture register is shifted down as bytes leave, so the next payload byte
  // always sits in the low 8 bits and no wide byte-select mux is needed.
  assign cap_d = CAP_W'(snapshot_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_bus_q   <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cap_q      <= cap_d;
            cnt_q      <= '0;
            tx_bus_q   <= HEADER;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_done_tick_i) begin
            if (cnt_q != LAST_IDX) begin
              cnt_q      <= cnt_q + CNT_W'(1);
              tx_bus_q   <= cap_q[7:0];
              cap_q      <= cap_q >> 8;
              tx_start_q <= 1'b1;
              state_q    <= SEND;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_bus_o   = tx_bus_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_snapshot_tx_serializer.sv
// Bench for snapshot_tx_serializer: a 16-bit and a 12-bit instance (both two payload
// bytes) run in lockstep against a transaction-level byte-stream model.
module tb_snapshot_tx_serializer;

  localparam int NB = 2;
  localparam logic [7:0] HDR = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, start, tick;
  logic [15:0] snap;
  logic        txStartA, busyA, doneA, txStartB, busyB, doneB;
  logic [7:0]  busA, busB;

  snapshot_tx_serializer #(.DATA_W(16), .HEADER(HDR)) dutA (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .snapshot_i(snap),
    .tx_done_tick_i(tick), .tx_start_o(txStartA), .tx_bus_o(busA),
    .busy_o(busyA), .done_o(doneA));

  snapshot_tx_serializer #(.DATA_W(12), .HEADER(HDR)) dutB (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .snapshot_i(snap[11:0]),
    .tx_done_tick_i(tick), .tx_start_o(txStartB), .tx_bus_o(busB),
    .busy_o(busyB), .done_o(doneB));

  // Model state: a dump is a list of NB+1 bytes; mNext is the next payload byte to emit.
  bit          mActive[2], mJust[2], mStart[2], mBusy[2], mDone[2];
  logic [7:0]  mBus[2];
  logic [15:0] mSnap[2];
  int          mNext[2];

  int total = 0, passed = 0, cyc = 0;
  int tickIn = -1, tickDelay = 5;
  logic [7:0] obsA[$], obsB[$], expA[$];
  int doneCntA = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] packLog(input logic [7:0] q[$]);
    logic [31:0] v;
    v = 32'(q.size()) << 24;
    for (int i = 0; i < 3 && i < q.size(); i++) v |= 32'(q[i]) << (16 - 8 * i);
    return v;
  endfunction

  task automatic modelUpdate(input int i);
    logic [15:0] mask;
    mask = (i == 0) ? 16'hFFFF : 16'h0FFF;
    if (!rstN) begin
      mActive[i] = 0; mJust[i] = 0; mStart[i] = 0; mBusy[i] = 0; mDone[i] = 0;
      mBus[i] = 8'h00; mNext[i] = 0;
    end else begin
      mStart[i] = 0;
      mDone[i]  = 0;
      if (!mActive[i]) begin
        if (start) begin
          mSnap[i] = snap & mask;
          mActive[i] = 1; mBusy[i] = 1; mStart[i] = 1; mJust[i] = 1;
          mBus[i] = HDR; mNext[i] = 1;
        end
      end else if (mJust[i]) begin
        mJust[i] = 0;
      end else if (tick) begin
        if (mNext[i] <= NB) begin
          mBus[i] = 8'(mSnap[i] >> (8 * (mNext[i] - 1)));
          mNext[i]++;
          mStart[i] = 1; mJust[i] = 1;
        end else begin
          mActive[i] = 0; mBusy[i] = 0; mDone[i] = 1;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("tx_start_A", 32'(txStartA), 32'(mStart[0]));
    checkOutput("tx_bus_A",   32'(busA),     32'(mBus[0]));
    checkOutput("busy_A",     32'(busyA),    32'(mBusy[0]));
    checkOutput("done_A",     32'(doneA),    32'(mDone[0]));
    checkOutput("tx_start_B", 32'(txStartB), 32'(mStart[1]));
    checkOutput("tx_bus_B",   32'(busB),     32'(mBus[1]));
    checkOutput("busy_B",     32'(busyB),    32'(mBusy[1]));
    checkOutput("done_B",     32'(doneB),    32'(mDone[1]));
    if (txStartA === 1'b1) obsA.push_back(busA);
    if (txStartB === 1'b1) obsB.push_back(busB);
    if (mStart[0]) expA.push_back(mBus[0]);
    if (doneA === 1'b1) doneCntA++;
  endtask

  // Drives one cycle of inputs (called at a negedge), updates the model at the
  // posedge, compares 1 time unit later and returns at the following negedge.
  task automatic applyStimulus(input bit st, input logic [15:0] sn, input bit stray, input bit rs);
    rstN = rs; start = st; snap = sn;
    if (tickIn >= 0) tickIn--;
    tick = (tickIn == 0) || stray;
    @(posedge clk);
    modelUpdate(0);
    modelUpdate(1);
    if (!rs) tickIn = -1;
    else if (mStart[0]) tickIn = tickDelay;
    #1;
    cyc++;
    compareAll();
    @(negedge clk);
  endtask

  task automatic runUntilIdle(input logic [15:0] sn, input int maxCycles);
    int n;
    n = 0;
    while ((mActive[0] || mActive[1]) && n < maxCycles) begin
      applyStimulus(0, sn, 0, 1);
      n++;
    end
    if (mActive[0] || mActive[1]) begin
      total++;
      $display("[TB] FAIL dump_timeout: still active after %0d cycles, required idle", maxCycles);
    end
  endtask

  task automatic clearLogs();
    obsA.delete(); obsB.delete(); expA.delete(); doneCntA = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      mActive[i] = 0; mJust[i] = 0; mStart[i] = 0; mBusy[i] = 0; mDone[i] = 0;
      mBus[i] = 8'h00; mNext[i] = 0; mSnap[i] = 16'h0;
    end
    rstN = 1'b0; start = 1'b0; tick = 1'b0; snap = 16'h0;
    @(negedge clk);
    applyStimulus(0, 16'h0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0);
    applyStimulus(0, 16'h0, 0, 1);

    // Basic dump with a 5-cycle uart turnaround.
    clearLogs();
    applyStimulus(1, 16'h1234, 0, 1);
    runUntilIdle(16'h1234, 100);
    checkOutput("seq_1234_A", packLog(obsA), 32'h03A53412);
    checkOutput("model_1234_A", packLog(expA), 32'h03A53412);
    checkOutput("seq_1234_B", packLog(obsB), 32'h03A53402);
    checkOutput("done_count_1234", 32'(doneCntA), 32'd1);

    // Partial last byte on the 12-bit instance is zero-padded.
    clearLogs();
    applyStimulus(1, 16'hFABC, 0, 1);
    runUntilIdle(16'hFABC, 100);
    checkOutput("seq_FABC_A", packLog(obsA), 32'h03A5BCFA);
    checkOutput("seq_FABC_B", packLog(obsB), 32'h03A5BC0A);

    // Start while busy with a changed snapshot is ignored.
    clearLogs();
    applyStimulus(1, 16'h1234, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 16'h1234, 0, 1);
    applyStimulus(1, 16'hFFFF, 0, 1);
    runUntilIdle(16'hFFFF, 100);
    checkOutput("seq_restart_ignored", packLog(obsA), 32'h03A53412);
    checkOutput("done_count_restart", 32'(doneCntA), 32'd1);

    // Reset right after the second tx_start aborts the dump for good.
    clearLogs();
    applyStimulus(1, 16'h1234, 0, 1);
    n = 0;
    while (obsA.size() < 2 && n < 40) begin
      applyStimulus(0, 16'h1234, 0, 1);
      n++;
    end
    applyStimulus(0, 16'h1234, 0, 0);
    checkOutput("abort_tx_start", 32'(txStartA), 32'd0);
    checkOutput("abort_busy", 32'(busyA), 32'd0);
    checkOutput("abort_tx_bus", 32'(busA), 32'h00);
    for (int i = 0; i < 20; i++) applyStimulus(0, 16'h1234, 0, 1);
    checkOutput("abort_no_more_bytes", packLog(obsA), 32'h02A53400);

    // Stray ticks in IDLE, then a dump.
    clearLogs();
    for (int i = 0; i < 6; i++) applyStimulus(0, 16'h00FF, i[0], 1);
    checkOutput("stray_no_bytes", 32'(obsA.size()), 32'd0);
    applyStimulus(1, 16'h00FF, 0, 1);
    runUntilIdle(16'h00FF, 100);
    checkOutput("seq_00FF_A", packLog(obsA), 32'h03A5FF00);
    checkOutput("seq_00FF_B", packLog(obsB), 32'h03A5FF00);

    // Start held across the done pulse restarts immediately.
    clearLogs();
    tickDelay = 3;
    n = 0;
    applyStimulus(1, 16'h5678, 0, 1);
    while (doneA !== 1'b1 && n < 60) begin
      applyStimulus(1, 16'h5678, 0, 1);
      n++;
    end
    checkOutput("held_done_seen", 32'(doneA), 32'd1);
    applyStimulus(1, 16'h5678, 0, 1);
    checkOutput("held_restart_tx_start", 32'(txStartA), 32'd1);
    checkOutput("held_restart_header", 32'(busA), 32'hA5);
    runUntilIdle(16'h5678, 100);

    // Randomized traffic: random starts, snapshots, turnaround, stray ticks and resets.
    for (int i = 0; i < 3000; i++) begin
      bit st, stray, rs;
      tickDelay = $urandom_range(2, 7);
      st    = ($urandom % 8) == 0;
      stray = (!mActive[0] || mJust[0]) && (($urandom % 6) == 0);
      rs    = ($urandom % 200) != 0;
      applyStimulus(st, 16'($urandom), stray, rs);
    end
    runUntilIdle(16'h0, 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
